eeprom_ctrl: RTL and testbench

//  Command front-end for the I2C EEPROM driver (iic_drive), sitting directly upstream of it.
//  - Accepts byte-stream write and read requests of 0..255 bytes.
//  - Splits writes into page-aligned bursts and reads into single-byte transactions.
//  - Buffers write data, inserts the EEPROM write-cycle (tWR) delay between bursts,
//    and streams read bytes back to the user.

---
 rtl/eeprom_pkg.sv | 26 ++
 rtl/eeprom_wbuf_fifo.sv | 61 ++++++
 rtl/eeprom_ctrl.sv | 173 +++++++++++++++++
 tb/tb_eeprom_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eeprom_pkg
//  Purpose  : Shared command-type codes and FSM state encoding for the
//             EEPROM command front-end.
//  Revision : 1.0  initial release
// ============================================================================
package eeprom_pkg;

  // Command / operation type codes shared with the I2C driver
  localparam logic [1:0] P_W = 2'd1;
  localparam logic [1:0] P_R = 2'd2;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_ISSUE     = 3'd2,
    S_BUSY      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_TWR       = 3'd5,
    S_FIN       = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/eeprom_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : eeprom_wbuf_fifo
//  Purpose  : Synchronous 8-bit write-data FIFO with occupancy count.
//             Pushes while full are dropped; pops while empty are ignored.
//             The head byte is presented combinationally on dout.
//  Revision : 1.0  initial release
// ============================================================================
module eeprom_wbuf_fifo #(
  parameter int P_DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic [$clog2(P_DEPTH):0]   count
);

  localparam int            AW       = $clog2(P_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(P_DEPTH);

  logic [7:0]    mem [P_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage array: written only on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/eeprom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : eeprom_ctrl
//  Purpose  : Command front-end for the I2C EEPROM driver. Splits writes into
//             page-aligned bursts and reads into single-byte transactions,
//             buffers write data, and waits out tWR after every write burst.
//  Revision : 1.0  initial release
// ============================================================================
module eeprom_ctrl #(
  parameter logic [6:0] P_DEV_ADDR   = 7'h50,
  parameter int         P_PAGE_SIZE  = 32,
  parameter int         P_TWR_CYCLES = 500000,
  parameter int         P_BUF_DEPTH  = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_type,
  input  logic [15:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_len,
  input  logic [7:0]  i_wdata,
  input  logic        i_wdata_valid,
  output logic        o_wbuf_full,
  output logic [7:0]  o_rdata,
  output logic        o_rdata_valid,
  output logic        o_done,
  output logic [6:0]  o_drive,
  output logic [15:0] o_operation_addr,
  output logic [7:0]  o_operation_len,
  output logic [1:0]  o_operation_type,
  output logic        o_operation_valid,
  input  logic        i_operation_ready,
  input  logic        i_write_req,
  output logic [7:0]  o_write_data,
  input  logic [7:0]  i_read_data,
  input  logic        i_read_valid
);

  import eeprom_pkg::*;

  localparam int          CW         = $clog2(P_BUF_DEPTH) + 1;
  localparam logic [7:0]  PAGE_MASK  = 8'(P_PAGE_SIZE - 1);
  localparam logic [8:0]  PAGE_SIZE9 = 9'(P_PAGE_SIZE);
  localparam logic [19:0] TWR_LAST   = 20'(P_TWR_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [15:0]   addr;
  logic [7:0]    rem;
  logic [7:0]    op_len;
  logic [1:0]    typ;
  logic [19:0]   twr_cnt;
  logic [CW-1:0] wcount;
  logic [7:0]    fifo_head;
  logic          len_ok;
  logic          accept;
  logic          typ_ok;
  logic [7:0]    page_off;
  logic [8:0]    room;
  logic [7:0]    burst_len;

  eeprom_wbuf_fifo #(
    .P_DEPTH (P_BUF_DEPTH)
  ) u_wbuf (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_wdata_valid),
    .din   (i_wdata),
    .pop   (i_write_req),
    .dout  (fifo_head),
    .full  (o_wbuf_full),
    .count (wcount)
  );

  // A write is only taken once all of its data is already buffered, so the
  // driver can never pop an empty FIFO.
  assign len_ok      = (i_cmd_type != P_W) || (wcount >= {{(CW-8){1'b0}}, i_cmd_len});
  assign o_cmd_ready = (state == S_IDLE) && len_ok;
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign typ_ok      = (typ == P_W) || (typ == P_R);

  // Bytes left in the current page; 9 bits because a full page can be 256
  assign page_off  = addr[7:0] & PAGE_MASK;
  assign room      = PAGE_SIZE9 - {1'b0, page_off};
  assign burst_len = (typ == P_R)           ? 8'd1 :
                     ({1'b0, rem} < room)   ? rem  : room[7:0];

  assign o_drive          = P_DEV_ADDR;
  assign o_operation_addr = addr;
  assign o_operation_len  = op_len;
  assign o_operation_type = typ;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and strobe outputs
  always_comb begin
    state_nx          = state;
    o_operation_valid = 1'b0;
    o_done            = 1'b0;
    case (state)
      S_IDLE:      if (accept) state_nx = S_CALC;
      S_CALC:      state_nx = ((rem == 8'd0) || !typ_ok) ? S_FIN : S_ISSUE;
      S_ISSUE: begin
        o_operation_valid = 1'b1;
        if (i_operation_ready) state_nx = S_BUSY;
      end
      // Driver's ready is still high here, so it must not be sampled
      S_BUSY:      state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (i_operation_ready) state_nx = (typ == P_W) ? S_TWR : S_CALC;
      S_TWR:       if (twr_cnt == TWR_LAST) state_nx = S_CALC;
      S_FIN: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default:     state_nx = S_IDLE;
    endcase
  end

  // Command context: address/remaining count, burst length and tWR timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr    <= '0;
      rem     <= '0;
      typ     <= '0;
      op_len  <= '0;
      twr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr <= i_cmd_addr;
            rem  <= i_cmd_len;
            typ  <= i_cmd_type;
          end
        end
        S_CALC:  op_len <= burst_len;
        S_WAIT_DONE: begin
          if (i_operation_ready) begin
            addr    <= addr + {8'd0, op_len};
            rem     <= rem - op_len;
            twr_cnt <= '0;
          end
        end
        S_TWR:   twr_cnt <= twr_cnt + 20'd1;
        default: ;
      endcase
    end
  end

  // Write byte to driver: FIFO head captured on the request that pops it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            o_write_data <= '0;
    else if (i_write_req) o_write_data <= fifo_head;
  end

  // Read byte to user, one-cycle registered strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
    end else begin
      o_rdata_valid <= i_read_valid;
      if (i_read_valid) o_rdata <= i_read_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eeprom_ctrl
//  Purpose  : Self-checking bench for eeprom_ctrl with a behavioural I2C
//             driver model, table-driven command vectors and hand-written
//             sequences for flow control, reset abort and FIFO boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eeprom_ctrl;

  import eeprom_pkg::*;

  localparam int PAGE  = 32;
  localparam int TWR   = 20;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  wdata;
  logic        wdata_valid, wbuf_full;
  logic [7:0]  rdata;
  logic        rdata_valid, done;
  logic [6:0]  drive;
  logic [15:0] op_addr;
  logic [7:0]  op_len;
  logic [1:0]  op_type;
  logic        op_valid, op_ready;
  logic        write_req;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        read_valid;

  eeprom_ctrl #(
    .P_DEV_ADDR   (7'h50),
    .P_PAGE_SIZE  (PAGE),
    .P_TWR_CYCLES (TWR),
    .P_BUF_DEPTH  (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cmd_valid       (cmd_valid),
    .o_cmd_ready       (cmd_ready),
    .i_cmd_type        (cmd_type),
    .i_cmd_addr        (cmd_addr),
    .i_cmd_len         (cmd_len),
    .i_wdata           (wdata),
    .i_wdata_valid     (wdata_valid),
    .o_wbuf_full       (wbuf_full),
    .o_rdata           (rdata),
    .o_rdata_valid     (rdata_valid),
    .o_done            (done),
    .o_drive           (drive),
    .o_operation_addr  (op_addr),
    .o_operation_len   (op_len),
    .o_operation_type  (op_type),
    .o_operation_valid (op_valid),
    .i_operation_ready (op_ready),
    .i_write_req       (write_req),
    .o_write_data      (write_data),
    .i_read_data       (read_data),
    .i_read_valid      (read_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] op_addr_q[$];
  logic [7:0]  op_len_q[$];
  logic [1:0]  op_typ_q[$];
  int          op_cyc_q[$];
  int          end_cyc_q[$];
  int          done_cyc_q[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  rd_src[$];
  bit          stall = 1'b0;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] a;
    logic [7:0]  l;
    int          nops;
    logic [15:0] a0, a1, a2;
    logic [7:0]  l0, l1, l2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_a(input vec_t v, input int i);
    case (i)
      0:       return v.a0;
      1:       return v.a1;
      default: return v.a2;
    endcase
  endfunction

  function automatic logic [7:0] exp_l(input vec_t v, input int i);
    case (i)
      0:       return v.l0;
      1:       return v.l1;
      default: return v.l2;
    endcase
  endfunction

  task automatic clr();
    op_addr_q.delete(); op_len_q.delete(); op_typ_q.delete();
    op_cyc_q.delete();  end_cyc_q.delete(); done_cyc_q.delete();
    wr_q.delete();      rd_q.delete();      rd_src.delete();
  endtask

  task automatic push(input logic [7:0] b);
    wdata = b; wdata_valid = 1'b1;
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  // Present a command, wait for acceptance, then wait for o_done
  task automatic run_cmd(input logic [1:0] t, input logic [15:0] a, input logic [7:0] l,
                         output int acc);
    int g;
    int d0;
    d0  = done_cyc_q.size();
    acc = -1;
    cmd_type = t; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    #1;
    g = 0;
    while (!cmd_ready && g < 300) begin
      @(negedge clk); #1; g++;
    end
    if (!cmd_ready) begin
      chk("accept_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_type = 2'd0;
    g = 0;
    while (done_cyc_q.size() == d0 && g < 5000) begin
      @(negedge clk); g++;
    end
    if (done_cyc_q.size() == d0) chk("done_wait", done_cyc_q.size(), d0 + 1);
    @(negedge clk);
  endtask

  // Behavioural iic_drive: ready drops one cycle after the handshake
  initial begin
    logic [7:0] len_l;
    logic [1:0] typ_l;
    op_ready = 1'b1; write_req = 1'b0; read_valid = 1'b0; read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && op_valid && op_ready) begin
        len_l = op_len; typ_l = op_type;
        op_addr_q.push_back(op_addr); op_len_q.push_back(op_len);
        op_typ_q.push_back(op_type);  op_cyc_q.push_back(cyc);
        @(negedge clk);
        @(negedge clk);
        op_ready = 1'b0;
        if (stall) begin
          while (stall) @(negedge clk);
        end else if (typ_l == P_W) begin
          for (int i = 0; i < int'(len_l); i++) begin
            write_req = 1'b1;
            @(negedge clk);
            write_req = 1'b0;
            wr_q.push_back(write_data);
            @(negedge clk);
          end
        end else begin
          @(negedge clk);
          read_data  = (rd_src.size() > 0) ? rd_src.pop_front() : 8'h00;
          read_valid = 1'b1;
          @(negedge clk);
          read_valid = 1'b0;
        end
        op_ready = 1'b1;
        end_cyc_q.push_back(cyc);
      end
    end
  end

  // User-side monitor: completion strobes and returned read bytes
  initial begin
    forever begin
      @(negedge clk);
      if (done)        done_cyc_q.push_back(cyc);
      if (rdata_valid) rd_q.push_back(rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int NV = 8;
  vec_t       vt[NV];
  logic [7:0] rd_pat[3];

  initial begin
    int acc;
    int gap;
    int g;
    int errs;

    vt[0] = '{P_W,  16'h001C, 8'd10, 2, 16'h001C, 16'h0020, 16'h0000, 8'd4,  8'd6,  8'd0};
    vt[1] = '{P_R,  16'h0100, 8'd3,  3, 16'h0100, 16'h0101, 16'h0102, 8'd1,  8'd1,  8'd1};
    vt[2] = '{P_W,  16'hFFFE, 8'd4,  2, 16'hFFFE, 16'h0000, 16'h0000, 8'd2,  8'd2,  8'd0};
    vt[3] = '{P_W,  16'h0000, 8'd0,  0, 16'h0000, 16'h0000, 16'h0000, 8'd0,  8'd0,  8'd0};
    vt[4] = '{2'd0, 16'h0005, 8'd5,  0, 16'h0000, 16'h0000, 16'h0000, 8'd0,  8'd0,  8'd0};
    vt[5] = '{2'd3, 16'h0040, 8'd2,  0, 16'h0000, 16'h0000, 16'h0000, 8'd0,  8'd0,  8'd0};
    vt[6] = '{P_W,  16'h0040, 8'd32, 1, 16'h0040, 16'h0000, 16'h0000, 8'd32, 8'd0,  8'd0};
    vt[7] = '{P_W,  16'h00F0, 8'd40, 2, 16'h00F0, 16'h0100, 16'h0000, 8'd16, 8'd24, 8'd0};
    rd_pat[0] = 8'hA5; rd_pat[1] = 8'h5A; rd_pat[2] = 8'hC3;

    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_drive",     drive, 7'h50);
    chk("rst_op_valid",  op_valid, 0);
    chk("rst_op_addr",   op_addr, 0);
    chk("rst_op_len",    op_len, 0);
    chk("rst_op_type",   op_type, 0);
    chk("rst_done",      done, 0);
    chk("rst_rdata_vld", rdata_valid, 0);
    chk("rst_rdata",     rdata, 0);
    chk("rst_wdata",     write_data, 0);
    chk("rst_full",      wbuf_full, 0);
    @(negedge clk);

    // ---------------- table-driven commands ----------------
    for (int k = 0; k < NV; k++) begin
      clr();
      gap = (vt[k].t == P_W) ? TWR + 2 : 2;
      if (vt[k].t == P_W)
        for (int i = 0; i < int'(vt[k].l); i++) push(8'(k * 32 + i));
      if (vt[k].t == P_R)
        for (int i = 0; i < int'(vt[k].l); i++) rd_src.push_back(rd_pat[i % 3]);
      run_cmd(vt[k].t, vt[k].a, vt[k].l, acc);
      chk($sformatf("v%0d_op_count", k), op_addr_q.size(), vt[k].nops);
      for (int i = 0; i < vt[k].nops && i < op_addr_q.size(); i++) begin
        chk($sformatf("v%0d_op%0d_addr", k, i), op_addr_q[i], exp_a(vt[k], i));
        chk($sformatf("v%0d_op%0d_len", k, i),  op_len_q[i],  exp_l(vt[k], i));
        chk($sformatf("v%0d_op%0d_type", k, i), op_typ_q[i],  vt[k].t);
        if (i > 0 && end_cyc_q.size() >= i)
          chk($sformatf("v%0d_op%0d_gap", k, i), op_cyc_q[i] - end_cyc_q[i-1], gap);
      end
      chk($sformatf("v%0d_done_count", k), done_cyc_q.size(), 1);
      if (done_cyc_q.size() > 0) begin
        if (vt[k].nops == 0)
          chk($sformatf("v%0d_done_latency", k), done_cyc_q[0] - acc, 2);
        else if (end_cyc_q.size() > 0)
          chk($sformatf("v%0d_done_after_last", k), done_cyc_q[0] - end_cyc_q[$], gap);
      end
      if (vt[k].t == P_W) begin
        chk($sformatf("v%0d_wr_bytes", k), wr_q.size(), vt[k].l);
        errs = 0;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 8'(k * 32 + i)) errs++;
        chk($sformatf("v%0d_wr_data_errs", k), errs, 0);
      end
      if (vt[k].t == P_R) begin
        chk($sformatf("v%0d_rd_bytes", k), rd_q.size(), vt[k].l);
        for (int i = 0; i < rd_q.size(); i++)
          chk($sformatf("v%0d_rd%0d", k, i), rd_q[i], rd_pat[i % 3]);
      end
    end

    // ---------------- write held off until FIFO has the data ----------------
    clr();
    push(8'h11); push(8'h22);
    cmd_type = P_W; cmd_addr = 16'h0200; cmd_len = 8'd4; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("gate_ready_low", cmd_ready, 0);
    end
    push(8'h33); #1;
    chk("gate_ready_low3", cmd_ready, 0);
    push(8'h44);
    run_cmd(P_W, 16'h0200, 8'd4, acc);
    chk("gate_ops", op_addr_q.size(), 1);
    if (op_addr_q.size() > 0) begin
      chk("gate_op_addr", op_addr_q[0], 16'h0200);
      chk("gate_op_len",  op_len_q[0],  8'd4);
    end
    chk("gate_wr_bytes", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("gate_wr0", wr_q[0], 8'h11); chk("gate_wr1", wr_q[1], 8'h22);
      chk("gate_wr2", wr_q[2], 8'h33); chk("gate_wr3", wr_q[3], 8'h44);
    end

    // ---------------- reset while waiting for driver ----------------
    clr();
    stall = 1'b1;
    cmd_type = P_R; cmd_addr = 16'h0300; cmd_len = 8'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_type = 2'd0;
    g = 0;
    while (op_addr_q.size() == 0 && g < 100) begin @(negedge clk); g++; end
    chk("abort_op_issued", op_addr_q.size(), 1);
    push(8'h77); push(8'h78);
    rst = 1'b1; #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_op_valid",  op_valid, 0);
    chk("abort_op_addr",   op_addr, 0);
    chk("abort_op_len",    op_len, 0);
    chk("abort_op_type",   op_type, 0);
    chk("abort_done",      done, 0);
    chk("abort_full",      wbuf_full, 0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done",  done_cyc_q.size(), 0);
    chk("abort_no_rdata", rd_q.size(), 0);
    cmd_type = P_W; cmd_len = 8'd1; #1;
    chk("abort_fifo_empty", cmd_ready, 0);
    cmd_type = 2'd0;
    @(negedge clk);
    push(8'h99);
    clr();
    run_cmd(P_W, 16'h0010, 8'd1, acc);
    chk("post_abort_ops", op_addr_q.size(), 1);
    if (op_addr_q.size() > 0) chk("post_abort_addr", op_addr_q[0], 16'h0010);
    chk("post_abort_bytes", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("post_abort_data", wr_q[0], 8'h99);

    // ---------------- FIFO full, dropped push, push during pops ----------------
    clr();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    #1;
    chk("full_flag", wbuf_full, 1);
    push(8'hEE);
    fork
      run_cmd(P_W, 16'h0000, 8'd255, acc);
      begin
        g = 0;
        while (wr_q.size() < 100 && g < 3000) begin @(negedge clk); g++; end
        wdata = 8'hAB; wdata_valid = 1'b1;
        @(negedge clk);
        wdata = 8'hCD;
        @(negedge clk);
        wdata_valid = 1'b0;
      end
    join
    chk("full_ops", op_addr_q.size(), 8);
    if (op_addr_q.size() == 8) begin
      chk("full_last_addr", op_addr_q[7], 16'h00E0);
      chk("full_last_len",  op_len_q[7],  8'd31);
    end
    chk("full_bytes", wr_q.size(), 255);
    errs = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 8'(i)) errs++;
    chk("full_data_errs", errs, 0);
    #1;
    chk("full_cleared", wbuf_full, 0);
    @(negedge clk);
    clr();
    run_cmd(P_W, 16'h1000, 8'd3, acc);
    chk("tail_bytes", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      chk("tail_kept_last", wr_q[0], 8'hFF);
      chk("tail_push_a",    wr_q[1], 8'hAB);
      chk("tail_push_b",    wr_q[2], 8'hCD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
